pong_paddle_seq: RTL and testbench

//  Sequences the paddle-position datapath that feeds the PONG circuit's PAD1_OUT/PAD2_OUT inputs.

---
 rtl/pong_paddle_seq.sv | 210 +++++++++++++++++++++
 tb/tb_pong_paddle_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_paddle_seq.sv
// pong_paddle_seq
//   Paddle-position sequencer between the input layer (keyboard, joystick,
//   analog) and the PONG core. It does three jobs:
//     * integrates digital up/down input into a clamped position, once per frame
//     * snapshots each player's effective position when PONG fires the paddle trigger
//     * runs per-line counters; each pad output stays high until its counter
//       reaches that player's snapshot
//
// Optional feature (macro PONG_PADDLE_ACCEL_EN):
//   When defined, each player has a held-frame counter. Once a direction has been
//   held for ACCEL_FRAMES consecutive frames, the step size doubles. When the
//   macro is undefined the step is always the base delta and the accel counters
//   are not built.
//
// Parameters
//   UGAP         top clamp (minimum legal position)
//   LGAP         bottom clamp; maximum legal position = 255-LGAP
//   INIT_POS     digital position and snapshot value loaded at reset
//   ACCEL_FRAMES held frames before the step doubles (accel build only)
//
// Ports
//   clk_sys            in   system clock
//   reset_n            in   asynchronous assert, active-low reset
//   hsync, vsync       in   PONG sync levels; rising edges are detected internally
//   pad_trg_n          in   PONG paddle trigger, active low
//   speed              in   0: base delta 4, 1: base delta 8
//   up1/dn1, up2/dn2   in   digital direction inputs per player
//   ana_en1/2          in   1: take that player's position from ana_pos1/2
//   ana_pos1/2  [7:0]  in   analog positions (already range-mapped by the caller)
//   pad1_out/pad2_out  out  to PONG PAD1_OUT / PAD2_OUT
//   p1pos/p2pos [7:0]  out  current effective positions (debug/OSD)
module pong_paddle_seq #(
  parameter int UGAP     = 23,
  parameter int LGAP     = 13,
  parameter int INIT_POS = 114
`ifdef PONG_PADDLE_ACCEL_EN
  ,
  parameter int ACCEL_FRAMES = 8
`endif
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       pad_trg_n,
  input  logic       speed,
  input  logic       up1,
  input  logic       dn1,
  input  logic       up2,
  input  logic       dn2,
  input  logic       ana_en1,
  input  logic [7:0] ana_pos1,
  input  logic       ana_en2,
  input  logic [7:0] ana_pos2,
  output logic       pad1_out,
  output logic       pad2_out,
  output logic [7:0] p1pos,
  output logic [7:0] p2pos
);

  localparam logic [7:0] POS_MIN  = 8'(UGAP);
  localparam logic [7:0] POS_MAX  = 8'(255 - LGAP);
  localparam logic [7:0] POS_INIT = 8'(INIT_POS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic hsync_q_reg, vsync_q_reg;
  logic hsync_edge,  vsync_edge;

  // Per-player views of the ports so both players share one generate body.
  logic [1:0]      up_v, dn_v, ana_en_v, pad_v, done_v;
  logic [1:0][7:0] ana_pos_v, eff_pos;

  assign up_v      = {up2, up1};
  assign dn_v      = {dn2, dn1};
  assign ana_en_v  = {ana_en2, ana_en1};
  assign ana_pos_v = {ana_pos2, ana_pos1};

  // Sync edge detection. History clears to 0 on reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q_reg <= 1'b0;
      vsync_q_reg <= 1'b0;
    end else begin
      hsync_q_reg <= hsync;
      vsync_q_reg <= vsync;
    end
  end

  assign hsync_edge = hsync & ~hsync_q_reg;
  assign vsync_edge = vsync & ~vsync_q_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    logic [7:0] pos_reg,  pos_next;
    logic [7:0] cnt_reg,  cnt_next;
    logic [7:0] snap_reg, snap_next;
    logic       pad_reg,  pad_next;
    logic       done;
    logic [7:0] delta;
    logic [8:0] lo_lim, sum;

`ifdef PONG_PADDLE_ACCEL_EN
    localparam logic [3:0] HELD_SAT = 4'(ACCEL_FRAMES);
    logic [3:0] held_reg, held_next;

    // Counts consecutive frames with exactly one direction held.
    always_comb begin
      held_next = held_reg;
      if (vsync_edge) begin
        if (up_v[gi] ^ dn_v[gi]) begin
          if (held_reg != HELD_SAT) held_next = held_reg + 4'd1;
        end else begin
          held_next = '0;
        end
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) held_reg <= '0;
      else          held_reg <= held_next;
    end
`endif

    // Digital integrator. Limits are compared in 9 bits so neither clamp can wrap.
    always_comb begin
      delta = speed ? 8'd8 : 8'd4;
`ifdef PONG_PADDLE_ACCEL_EN
      if (held_reg == HELD_SAT) delta = delta << 1;
`endif
      lo_lim   = {1'b0, POS_MIN} + {1'b0, delta};
      sum      = {1'b0, pos_reg} + {1'b0, delta};
      pos_next = pos_reg;
      if (vsync_edge && (up_v[gi] ^ dn_v[gi])) begin
        if (up_v[gi]) pos_next = ({1'b0, pos_reg} < lo_lim) ? POS_MIN : (pos_reg - delta);
        else          pos_next = (sum > {1'b0, POS_MAX}) ? POS_MAX : sum[7:0];
      end
    end

    assign eff_pos[gi] = !ana_en_v[gi]            ? pos_reg :
                         (ana_pos_v[gi] < POS_MIN) ? POS_MIN :
                         (ana_pos_v[gi] > POS_MAX) ? POS_MAX : ana_pos_v[gi];

    // Line counter / snapshot / pad output. A low trigger takes priority over
    // an hsync edge in the same cycle, so the clear always wins.
    always_comb begin
      cnt_next  = cnt_reg;
      snap_next = snap_reg;
      pad_next  = 1'b0;
      if (!pad_trg_n) begin
        cnt_next  = '0;
        snap_next = eff_pos[gi];
        pad_next  = 1'b1;
      end else if (state_reg == ST_ARM || state_reg == ST_COUNT) begin
        if (state_reg == ST_COUNT && hsync_edge && cnt_reg != 8'hFF)
          cnt_next = cnt_reg + 8'd1;
        pad_next = (cnt_next < snap_reg);
      end
      done = (cnt_next >= snap_reg);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        pos_reg  <= POS_INIT;
        cnt_reg  <= '0;
        snap_reg <= POS_INIT;
        pad_reg  <= 1'b0;
      end else begin
        pos_reg  <= pos_next;
        cnt_reg  <= cnt_next;
        snap_reg <= snap_next;
        pad_reg  <= pad_next;
      end
    end

    assign pad_v[gi]  = pad_reg;
    assign done_v[gi] = done;
  end

  // Shared sequencing FSM.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!pad_trg_n) begin
      state_next = ST_ARM;          // from any state: (re)start the sequence
    end else begin
      case (state_reg)
        ST_ARM:   state_next = ST_COUNT;
        ST_COUNT: if (&done_v) state_next = ST_DONE;
        default:  state_next = state_reg;
      endcase
    end
  end

  assign pad1_out = pad_v[0];
  assign pad2_out = pad_v[1];
  assign p1pos    = eff_pos[0];
  assign p2pos    = eff_pos[1];

endmodule

// File: tb/tb_pong_paddle_seq.sv
module tb_pong_paddle_seq;

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       hsync     = 1'b0;
  logic       vsync     = 1'b0;
  logic       pad_trg_n = 1'b1;
  logic       speed     = 1'b0;
  logic       up1 = 1'b0, dn1 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
  logic       ana_en1 = 1'b0, ana_en2 = 1'b0;
  logic [7:0] ana_pos1 = 8'd0, ana_pos2 = 8'd0;
  logic       pad1_out, pad2_out;
  logic [7:0] p1pos, p2pos;

  pong_paddle_seq dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .pad_trg_n(pad_trg_n),
    .speed    (speed),
    .up1      (up1),
    .dn1      (dn1),
    .up2      (up2),
    .dn2      (dn2),
    .ana_en1  (ana_en1),
    .ana_pos1 (ana_pos1),
    .ana_en2  (ana_en2),
    .ana_pos2 (ana_pos2),
    .pad1_out (pad1_out),
    .pad2_out (pad2_out),
    .p1pos    (p1pos),
    .p2pos    (p2pos)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues: expected pad pulse widths (in hsyncs) and expected
  // positions after each frame.
  int w1_q[$];
  int w2_q[$];
  int ep1_q[$];
  int ep2_q[$];

  // Reference model state.
  int mpos[2];
  int mheld[2];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 23)  return 23;
    if (v > 242) return 242;
    return v;
  endfunction

  function automatic int eff(input int i);
    if (i == 0) return ana_en1 ? clampi(int'(ana_pos1)) : mpos[0];
    return ana_en2 ? clampi(int'(ana_pos2)) : mpos[1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mpos[i]  = 114;
      mheld[i] = 0;
    end
  endtask

  // One frame of the integrator rules, at behavioural level.
  task automatic model_frame();
    for (int i = 0; i < 2; i++) begin
      bit u, d;
      int delta;
      u = (i == 0) ? up1 : up2;
      d = (i == 0) ? dn1 : dn2;
      if (u ^ d) begin
        delta = speed ? 8 : 4;
`ifdef PONG_PADDLE_ACCEL_EN
        if (mheld[i] >= 8) delta = 2 * delta;
        mheld[i] = (mheld[i] >= 8) ? 8 : mheld[i] + 1;
`endif
        if (u) mpos[i] = (mpos[i] - delta < 23) ? 23 : mpos[i] - delta;
        else   mpos[i] = (mpos[i] + delta > 242) ? 242 : mpos[i] + delta;
      end else begin
        mheld[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic hs_pulse();
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
  endtask

  task automatic run_lines(input int n);
    repeat (n) hs_pulse();
  endtask

  task automatic vs_pulse();
    model_frame();
    ep1_q.push_back(eff(0));
    ep2_q.push_back(eff(1));
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  task automatic trigger(input bit push);
    if (push) begin
      w1_q.push_back(eff(0));
      w2_q.push_back(eff(1));
    end
    pad_trg_n = 1'b0; tick(); tick();
    pad_trg_n = 1'b1; tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {up1, dn1, up2, dn2} = 4'b0;
    {ana_en1, ana_en2}   = 2'b0;
    hsync = 1'b0; vsync = 1'b0; pad_trg_n = 1'b1; speed = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Monitor: measures each pad pulse width in hsync edges and compares it
  // with the scoreboard when the pulse ends.
  bit hs_prev = 1'b0, pp1 = 1'b0, pp2 = 1'b0;
  int c1 = 0, c2 = 0;
  initial begin
    forever begin
      bit hs_rise;
      @(negedge clk_sys);
      hs_rise = hsync && !hs_prev;
      hs_prev = hsync;
      if (pad1_out && hs_rise) c1++;
      if (pad2_out && hs_rise) c2++;
      if (pp1 && !pad1_out) begin
        if (w1_q.size() == 0) check("pad1_unexpected_pulse_width", c1, -1);
        else                  check("pad1_width", c1, w1_q.pop_front());
        c1 = 0;
      end
      if (pp2 && !pad2_out) begin
        if (w2_q.size() == 0) check("pad2_unexpected_pulse_width", c2, -1);
        else                  check("pad2_width", c2, w2_q.pop_front());
        c2 = 0;
      end
      pp1 = pad1_out;
      pp2 = pad2_out;
    end
  end

  // Monitor: one cycle after each vsync edge the positions must match the model.
  bit vs_prev = 1'b0, vs_flag = 1'b0;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (vs_flag) begin
        if (ep1_q.size() == 0) check("p1pos_unexpected_frame", int'(p1pos), -1);
        else                   check("p1pos_frame", int'(p1pos), ep1_q.pop_front());
        if (ep2_q.size() == 0) check("p2pos_unexpected_frame", int'(p2pos), -1);
        else                   check("p2pos_frame", int'(p2pos), ep2_q.pop_front());
      end
      vs_flag = reset_n && vsync && !vs_prev;
      vs_prev = vsync;
    end
  end

  initial begin
    int s0, s1;
    model_reset();
    do_reset();

    // Reset state.
    check("reset_pad1", int'(pad1_out), 0);
    check("reset_pad2", int'(pad2_out), 0);
    check("reset_p1pos", int'(p1pos), 114);
    check("reset_p2pos", int'(p2pos), 114);

    // Idle trigger with no input: both pulses 114 hsyncs wide.
    trigger(1'b1);
    run_lines(200);
    check("idle_p1pos", int'(p1pos), 114);

    // Re-trigger mid-COUNT, coincident with an hsync edge (clear wins).
    trigger(1'b1);
    run_lines(30);
    s0 = eff(0); s1 = eff(1);
    w1_q.push_back(30 + 1 + s0);
    w2_q.push_back(30 + 1 + s1);
    void'(w1_q.pop_front());   // first trigger never ends on its own
    void'(w2_q.pop_front());
    pad_trg_n = 1'b0; hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    pad_trg_n = 1'b1; tick();
    run_lines(250);

    // Top clamp.
    speed = 1'b0; up1 = 1'b1;
    repeat (30) vs_pulse();
    up1 = 1'b0;
    check("top_clamp_p1pos", int'(p1pos), 23);

    // Bottom clamp, then both directions held.
    speed = 1'b1; dn2 = 1'b1;
    repeat (30) vs_pulse();
    check("bottom_clamp_p2pos", int'(p2pos), 242);
    up2 = 1'b1;
    repeat (5) vs_pulse();
    {up2, dn2} = 2'b00;
    check("both_held_p2pos", int'(p2pos), 242);

    // Analog path clamping into the snapshot.
    ana_en1 = 1'b1; ana_pos1 = 8'd0;
    trigger(1'b1); run_lines(250);
    ana_pos1 = 8'd255;
    trigger(1'b1); run_lines(250);
    // Analog change mid-COUNT does not alter the running pulse.
    ana_pos1 = 8'd100;
    trigger(1'b1); run_lines(50);
    ana_pos1 = 8'd200;
    run_lines(200);
    ana_en1 = 1'b0;

    // Randomized frames and triggers.
    for (int it = 0; it < 8; it++) begin
      int nf;
      speed    = 1'($urandom_range(0, 1));
      ana_en1  = ($urandom_range(0, 3) == 0);
      ana_en2  = ($urandom_range(0, 3) == 0);
      ana_pos1 = 8'($urandom);
      ana_pos2 = 8'($urandom);
      nf = $urandom_range(3, 12);
      for (int f = 0; f < nf; f++) begin
        {up1, dn1, up2, dn2} = 4'($urandom);
        vs_pulse();
      end
      trigger(1'b1);
      run_lines(120);
      {up1, dn1, up2, dn2} = 4'($urandom);
      vs_pulse();                 // affects only the next snapshot
      run_lines(130);
    end
    {up1, dn1, up2, dn2} = 4'b0;
    {ana_en1, ana_en2}   = 2'b0;

    // Asynchronous reset mid-COUNT.
    do_reset();
    trigger(1'b1);
    run_lines(40);
    void'(w1_q.pop_front());
    void'(w2_q.pop_front());
    w1_q.push_back(40);
    w2_q.push_back(40);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_pad1", int'(pad1_out), 0);
    check("async_reset_pad2", int'(pad2_out), 0);
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      run_lines(5);
      check("post_reset_pad1_quiet", int'(pad1_out), 0);
      check("post_reset_pad2_quiet", int'(pad2_out), 0);
    end
    check("post_reset_p1pos", int'(p1pos), 114);

`ifdef PONG_PADDLE_ACCEL_EN
    // Acceleration after eight held frames.
    do_reset();
    speed = 1'b0; dn1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      vs_pulse();
      if (k == 8) check("accel_frame8_p1pos", int'(p1pos), 146);
      if (k == 9) check("accel_frame9_p1pos", int'(p1pos), 154);
    end
    dn1 = 1'b0; vs_pulse();
    dn1 = 1'b1; vs_pulse();
    check("accel_release_p1pos", int'(p1pos), 182);
    dn1 = 1'b0;
`endif

    tick(); tick(); tick();
    check("pad1_pending_left", w1_q.size(), 0);
    check("pad2_pending_left", w2_q.size(), 0);
    check("frame_pending_left", ep1_q.size() + ep2_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
